// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, reset PC,
// the NOP encoding reserved for bubble insertion, and the fetch FSM state type.
package fetch_unit_pkg;

   localparam int          DEF_PC_WIDTH    = 64;
   localparam int          DEF_INSTR_WIDTH = 32;
   localparam logic [63:0] DEF_RESET_PC    = 64'h0;
   localparam logic [31:0] NOP_INSTR       = 32'h00000013;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   // A fetch target is usable only when it sits on a 32-bit word boundary.
   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return |low_bits;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// master: the fetch unit itself; slave: the surrounding pipeline and memory.
interface fetch_unit_if import fetch_unit_pkg::*; #(
   parameter int PC_WIDTH    = DEF_PC_WIDTH,
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
);

   logic                   stall;
   logic                   redirect_valid;
   logic [PC_WIDTH-1:0]    redirect_target;
   logic                   imem_req_valid;
   logic                   imem_req_ready;
   logic [PC_WIDTH-1:0]    imem_addr;
   logic                   imem_rsp_valid;
   logic [INSTR_WIDTH-1:0] imem_rsp_data;
   logic [INSTR_WIDTH-1:0] instruction;
   logic [PC_WIDTH-1:0]    PC_Out;
   logic                   fetch_valid;
   logic                   fetch_misalign;

   modport master (
      input  stall, redirect_valid, redirect_target,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output imem_req_valid, imem_addr,
      output instruction, PC_Out, fetch_valid, fetch_misalign
   );

   modport slave (
      output stall, redirect_valid, redirect_target,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  imem_req_valid, imem_addr,
      input  instruction, PC_Out, fetch_valid, fetch_misalign
   );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry holding register that parks a fetched instruction and its PC while
// the IF/ID register is stalled and already occupied.
module fetch_hold_buf import fetch_unit_pkg::*; #(
   parameter int PC_WIDTH    = DEF_PC_WIDTH,
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_load,
   input  logic                   i_unload,
   input  logic                   i_clear,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   input  logic [PC_WIDTH-1:0]    i_pc,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [PC_WIDTH-1:0]    o_pc
);

   logic [INSTR_WIDTH-1:0] r_instr;
   logic [PC_WIDTH-1:0]    r_pc;

   // Empty the entry on unload or flush, otherwise capture on load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= '0;
         r_pc    <= '0;
      end else if (i_clear || i_unload) begin
         r_instr <= '0;
         r_pc    <= '0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end
   end

   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding IF/ID. Owns the PC, issues one word fetch at a
// time, absorbs a stalled response in a hold buffer and squashes fetches on redirect.
// Optional macro FETCH_MISALIGN_CHK_EN: report misaligned redirect targets instead
// of silently word-aligning them.
module fetch_unit import fetch_unit_pkg::*; #(
   parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
   parameter int                  INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEF_RESET_PC)
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus
);

   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

   fetch_state_e           r_state,       w_stateNext;
   logic [PC_WIDTH-1:0]    r_pc,          w_pcNext;
   logic                   r_squash,      w_squashNext;
   logic                   r_reqValid,    w_reqValidNext;
   logic [INSTR_WIDTH-1:0] r_instr,       w_instrNext;
   logic [PC_WIDTH-1:0]    r_pcOut,       w_pcOutNext;
   logic                   r_fetchValid,  w_fetchValidNext;
`ifdef FETCH_MISALIGN_CHK_EN
   logic                   r_misalign,    w_misalignNext;
   logic                   r_parked,      w_parkedNext;
`endif

   logic                   w_holdLoad;
   logic                   w_holdUnload;
   logic                   w_holdClear;
   logic [INSTR_WIDTH-1:0] w_holdInstr;
   logic [PC_WIDTH-1:0]    w_holdPc;
   logic [PC_WIDTH-1:0]    w_target;
   logic [PC_WIDTH-1:0]    w_pcPlus4;
   logic                   w_reqFire;
   logic                   w_slotFree;

`ifdef FETCH_MISALIGN_CHK_EN
   assign w_target = bus.redirect_target;
`else
   assign w_target = bus.redirect_target & ALIGN_MASK;
`endif

   assign w_pcPlus4  = r_pc + PC_WIDTH'(4);
   assign w_reqFire  = r_reqValid & bus.imem_req_ready;
   assign w_slotFree = ~bus.stall | ~r_fetchValid;

   fetch_hold_buf #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_holdBuf (
      .clk      (clk),
      .rst_n    (reset),
      .i_load   (w_holdLoad),
      .i_unload (w_holdUnload),
      .i_clear  (w_holdClear),
      .i_instr  (bus.imem_rsp_data),
      .i_pc     (r_pc),
      .o_instr  (w_holdInstr),
      .o_pc     (w_holdPc)
   );

   // Next-state, PC and IF/ID output decisions; redirect outranks everything else.
   always_comb begin
      w_stateNext      = r_state;
      w_pcNext         = r_pc;
      w_squashNext     = r_squash;
      w_instrNext      = r_instr;
      w_pcOutNext      = r_pcOut;
      w_fetchValidNext = r_fetchValid;
      w_holdLoad       = 1'b0;
      w_holdUnload     = 1'b0;
      w_holdClear      = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      w_misalignNext   = r_misalign;
      w_parkedNext     = r_parked;
`endif

      if (!bus.stall) begin
         w_fetchValidNext = 1'b0;
         w_instrNext      = '0;
`ifdef FETCH_MISALIGN_CHK_EN
         w_misalignNext   = 1'b0;
`endif
      end

      if (bus.redirect_valid) begin
         w_pcNext         = w_target;
         w_fetchValidNext = 1'b0;
         w_instrNext      = '0;
         w_holdClear      = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
         w_misalignNext   = 1'b0;
`endif
         case (r_state)
            REQ: begin
               if (w_reqFire) begin
                  w_stateNext  = WAIT;
                  w_squashNext = 1'b1;
               end
            end
            WAIT: begin
               if (bus.imem_rsp_valid) begin
                  w_stateNext  = REQ;
                  w_squashNext = 1'b0;
               end else begin
                  w_squashNext = 1'b1;
               end
            end
            HOLD: w_stateNext = REQ;
            default: w_stateNext = REQ;
         endcase
`ifdef FETCH_MISALIGN_CHK_EN
         if (is_misaligned(w_target[1:0])) begin
            w_fetchValidNext = 1'b1;
            w_pcOutNext      = w_target;
            w_misalignNext   = 1'b1;
            w_stateNext      = REQ;
            w_squashNext     = 1'b0;
            w_parkedNext     = 1'b1;
         end else begin
            w_parkedNext     = 1'b0;
         end
`endif
      end else begin
         case (r_state)
            REQ: begin
               if (w_reqFire) begin
                  w_stateNext = WAIT;
               end
            end
            WAIT: begin
               if (bus.imem_rsp_valid) begin
                  if (r_squash) begin
                     w_squashNext = 1'b0;
                     w_stateNext  = REQ;
                  end else if (w_slotFree) begin
                     w_instrNext      = bus.imem_rsp_data;
                     w_pcOutNext      = r_pc;
                     w_fetchValidNext = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
                     w_misalignNext   = 1'b0;
`endif
                     w_pcNext         = w_pcPlus4;
                     w_stateNext      = REQ;
                  end else begin
                     w_holdLoad  = 1'b1;
                     w_pcNext    = w_pcPlus4;
                     w_stateNext = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!bus.stall) begin
                  w_instrNext      = w_holdInstr;
                  w_pcOutNext      = w_holdPc;
                  w_fetchValidNext = 1'b1;
                  w_holdUnload     = 1'b1;
                  w_stateNext      = REQ;
               end
            end
            default: w_stateNext = REQ;
         endcase
      end

      w_reqValidNext = (w_stateNext == REQ);
`ifdef FETCH_MISALIGN_CHK_EN
      if (w_parkedNext) begin
         w_reqValidNext = 1'b0;
      end
`endif
   end

   // State, PC and IF/ID output registers; reset empties the stage immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= REQ;
         r_pc         <= RESET_PC;
         r_squash     <= 1'b0;
         r_reqValid   <= 1'b0;
         r_instr      <= '0;
         r_pcOut      <= '0;
         r_fetchValid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
         r_misalign   <= 1'b0;
         r_parked     <= 1'b0;
`endif
      end else begin
         r_state      <= w_stateNext;
         r_pc         <= w_pcNext;
         r_squash     <= w_squashNext;
         r_reqValid   <= w_reqValidNext;
         r_instr      <= w_instrNext;
         r_pcOut      <= w_pcOutNext;
         r_fetchValid <= w_fetchValidNext;
`ifdef FETCH_MISALIGN_CHK_EN
         r_misalign   <= w_misalignNext;
         r_parked     <= w_parkedNext;
`endif
      end
   end

   assign bus.imem_req_valid = r_reqValid;
   assign bus.imem_addr      = r_pc;
   assign bus.instruction    = r_instr;
   assign bus.PC_Out         = r_pcOut;
   assign bus.fetch_valid    = r_fetchValid;
`ifdef FETCH_MISALIGN_CHK_EN
   assign bus.fetch_misalign = r_misalign;
`else
   assign bus.fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against an in-order PC/instruction model of the fetch stream.
// Honours FETCH_MISALIGN_CHK_EN to select the misaligned-redirect expectations.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   fetch_unit_if bus ();

   fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Backstop so a wedged run still terminates.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Memory contents: a scrambled word per address so every PC has a distinct instruction.
   function automatic logic [31:0] memWord(input logic [63:0] addr);
      logic [31:0] lo;
      lo = addr[31:0];
      return (lo * 32'h9E3779B1) ^ 32'h00500093 ^ addr[63:32];
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clearInputs();
      bus.stall           = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = '0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_rsp_valid  = 1'b0;
      bus.imem_rsp_data   = '0;
   endtask

   task automatic releaseFromReset();
      clearInputs();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic waitReq(input string name);
      int n;
      n = 0;
      while (bus.imem_req_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (bus.imem_req_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_req_timeout: imem_req_valid=%b required 1", name, bus.imem_req_valid);
      end
   endtask

   task automatic doFetch(input logic [31:0] data, input string name);
      waitReq(name);
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data;
      step();
      bus.imem_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      clearInputs();
      reset = 1'b0;
      step();
      step();
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_fetch_valid: got %b required 0", bus.fetch_valid); end
      checks++; if (bus.instruction !== 32'h0) begin errors++; $display("[TB] FAIL rst_instruction: got %h required 0", bus.instruction); end
      checks++; if (bus.PC_Out !== 64'h0) begin errors++; $display("[TB] FAIL rst_pc_out: got %h required 0", bus.PC_Out); end
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid: got %b required 0", bus.imem_req_valid); end
      checks++; if (bus.fetch_misalign !== 1'b0) begin errors++; $display("[TB] FAIL rst_misalign: got %b required 0", bus.fetch_misalign); end
      checks++; if (bus.imem_addr !== DEF_RESET_PC) begin errors++; $display("[TB] FAIL rst_addr: got %h required %h", bus.imem_addr, DEF_RESET_PC); end
      reset = 1'b1;
      step();
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_first_req: got %b required 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 64'h0) begin errors++; $display("[TB] FAIL rst_first_addr: got %h required 0", bus.imem_addr); end
   endtask

   task automatic test_first_fetch();
      doFetch(32'h00500093, "first");
      checks++; if (bus.instruction !== 32'h00500093) begin errors++; $display("[TB] FAIL first_instr: got %h required 00500093", bus.instruction); end
      checks++; if (bus.PC_Out !== 64'h0) begin errors++; $display("[TB] FAIL first_pc_out: got %h required 0", bus.PC_Out); end
      checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid: got %b required 1", bus.fetch_valid); end
      checks++; if (bus.imem_addr !== 64'h4) begin errors++; $display("[TB] FAIL first_next_addr: got %h required 4", bus.imem_addr); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [3];
      words[0] = 32'h00100093;
      words[1] = NOP_INSTR;
      words[2] = 32'h00208113;
      releaseFromReset();
      for (int i = 0; i < 3; i++) begin
         waitReq("b2b");
         bus.imem_req_ready = 1'b1;
         step();
         bus.imem_req_ready = 1'b0;
         if (i > 0) begin
            checks++;
            if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_bubble%0d: fetch_valid=%b required 0", i, bus.fetch_valid); end
         end
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = words[i];
         step();
         bus.imem_rsp_valid = 1'b0;
         checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid%0d: got %b required 1", i, bus.fetch_valid); end
         checks++; if (bus.PC_Out !== 64'(i * 4)) begin errors++; $display("[TB] FAIL b2b_pc%0d: got %h required %h", i, bus.PC_Out, 64'(i * 4)); end
         checks++; if (bus.instruction !== words[i]) begin errors++; $display("[TB] FAIL b2b_instr%0d: got %h required %h", i, bus.instruction, words[i]); end
      end
   endtask

   task automatic test_stall_hold();
      releaseFromReset();
      doFetch(32'hAAAA0001, "stall");
      bus.stall = 1'b1;
      waitReq("stall");
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hBBBB0002;
      step();
      bus.imem_rsp_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid%0d: got %b required 1", i, bus.fetch_valid); end
         checks++; if (bus.instruction !== 32'hAAAA0001) begin errors++; $display("[TB] FAIL stall_instr%0d: got %h required aaaa0001", i, bus.instruction); end
         checks++; if (bus.PC_Out !== 64'h0) begin errors++; $display("[TB] FAIL stall_pc%0d: got %h required 0", i, bus.PC_Out); end
         checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_req%0d: got %b required 0", i, bus.imem_req_valid); end
         step();
      end
      bus.stall = 1'b0;
      step();
      checks++; if (bus.instruction !== 32'hBBBB0002) begin errors++; $display("[TB] FAIL unhold_instr: got %h required bbbb0002", bus.instruction); end
      checks++; if (bus.PC_Out !== 64'h4) begin errors++; $display("[TB] FAIL unhold_pc: got %h required 4", bus.PC_Out); end
      checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL unhold_valid: got %b required 1", bus.fetch_valid); end
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL unhold_req: got %b required 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 64'h8) begin errors++; $display("[TB] FAIL unhold_addr: got %h required 8", bus.imem_addr); end
   endtask

   task automatic test_redirect();
      releaseFromReset();
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready  = 1'b0;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 64'h100;
      step();
      bus.redirect_valid = 1'b0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEADBEEF;
      step();
      bus.imem_rsp_valid = 1'b0;
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_drop_valid: got %b required 0", bus.fetch_valid); end
      checks++; if (bus.instruction !== 32'h0) begin errors++; $display("[TB] FAIL redir_drop_instr: got %h required 0", bus.instruction); end
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_req: got %b required 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 64'h100) begin errors++; $display("[TB] FAIL redir_addr: got %h required 100", bus.imem_addr); end
      doFetch(32'h12345678, "redir");
      checks++; if (bus.PC_Out !== 64'h100) begin errors++; $display("[TB] FAIL redir_pc_out: got %h required 100", bus.PC_Out); end
      checks++; if (bus.instruction !== 32'h12345678) begin errors++; $display("[TB] FAIL redir_instr: got %h required 12345678", bus.instruction); end
      bus.stall           = 1'b1;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 64'h40;
      step();
      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_over_stall_valid: got %b required 0", bus.fetch_valid); end
      checks++; if (bus.instruction !== 32'h0) begin errors++; $display("[TB] FAIL redir_over_stall_instr: got %h required 0", bus.instruction); end
      checks++; if (bus.imem_addr !== 64'h40) begin errors++; $display("[TB] FAIL redir_over_stall_addr: got %h required 40", bus.imem_addr); end
   endtask

   task automatic test_reset_mid();
      releaseFromReset();
      doFetch(32'hCAFE0013, "rstmid");
      waitReq("rstmid");
      bus.imem_req_ready = 1'b1;
      step();
      bus.imem_req_ready = 1'b0;
      reset = 1'b0;
      #1;
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b required 0", bus.fetch_valid); end
      checks++; if (bus.instruction !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_instr: got %h required 0", bus.instruction); end
      checks++; if (bus.PC_Out !== 64'h0) begin errors++; $display("[TB] FAIL rstmid_pc_out: got %h required 0", bus.PC_Out); end
      checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_req: got %b required 0", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== DEF_RESET_PC) begin errors++; $display("[TB] FAIL rstmid_addr: got %h required %h", bus.imem_addr, DEF_RESET_PC); end
      step();
      reset = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEADBEEF;
      step();
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stray_valid0: got %b required 0", bus.fetch_valid); end
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL stray_req: got %b required 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== DEF_RESET_PC) begin errors++; $display("[TB] FAIL stray_addr: got %h required %h", bus.imem_addr, DEF_RESET_PC); end
      step();
      bus.imem_rsp_valid = 1'b0;
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL stray_valid1: got %b required 0", bus.fetch_valid); end
      checks++; if (bus.instruction !== 32'h0) begin errors++; $display("[TB] FAIL stray_instr: got %h required 0", bus.instruction); end
   endtask

   task automatic test_misalign();
      releaseFromReset();
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 64'h102;
      step();
      bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      checks++; if (bus.fetch_misalign !== 1'b1) begin errors++; $display("[TB] FAIL mis_flag: got %b required 1", bus.fetch_misalign); end
      checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL mis_valid: got %b required 1", bus.fetch_valid); end
      checks++; if (bus.PC_Out !== 64'h102) begin errors++; $display("[TB] FAIL mis_pc_out: got %h required 102", bus.PC_Out); end
      checks++; if (bus.instruction !== 32'h0) begin errors++; $display("[TB] FAIL mis_instr: got %h required 0", bus.instruction); end
      bus.imem_req_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_parked%0d: req_valid=%b required 0", i, bus.imem_req_valid); end
         if (i == 0) begin
            checks++; if (bus.fetch_misalign !== 1'b0) begin errors++; $display("[TB] FAIL mis_clear: got %b required 0", bus.fetch_misalign); end
         end
      end
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 64'h200;
      step();
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b0;
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL mis_unpark_req: got %b required 1", bus.imem_req_valid); end
      checks++; if (bus.imem_addr !== 64'h200) begin errors++; $display("[TB] FAIL mis_unpark_addr: got %h required 200", bus.imem_addr); end
`else
      checks++; if (bus.fetch_misalign !== 1'b0) begin errors++; $display("[TB] FAIL align_flag: got %b required 0", bus.fetch_misalign); end
      checks++; if (bus.imem_addr !== 64'h100) begin errors++; $display("[TB] FAIL align_addr: got %h required 100", bus.imem_addr); end
      checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL align_req: got %b required 1", bus.imem_req_valid); end
      doFetch(32'h0000A013, "align");
      checks++; if (bus.PC_Out !== 64'h100) begin errors++; $display("[TB] FAIL align_pc_out: got %h required 100", bus.PC_Out); end
`endif
   endtask

   task automatic test_random();
      logic [63:0] expPc;
      logic [63:0] pendAddr;
      logic [63:0] target;
      logic [31:0] prevInstr;
      logic [63:0] prevPcOut;
      logic        pending;
      logic        prevHold;
      logic        curFv;
      logic        stallNow;
      logic        redirNow;
      logic        readyNow;
      int          lat;
      int          accepted;

      releaseFromReset();
      expPc     = DEF_RESET_PC;
      pending   = 1'b0;
      prevHold  = 1'b0;
      prevInstr = '0;
      prevPcOut = '0;
      lat       = 0;
      accepted  = 0;

      for (int cyc = 0; cyc < 1500 && accepted < 60; cyc++) begin
         curFv = bus.fetch_valid;
         if (prevHold) begin
            checks++;
            if (curFv !== 1'b1 || bus.instruction !== prevInstr || bus.PC_Out !== prevPcOut) begin
               errors++;
               $display("[TB] FAIL rnd_stall_hold: got v=%b %h@%h required v=1 %h@%h",
                        curFv, bus.instruction, bus.PC_Out, prevInstr, prevPcOut);
            end
         end
         if (curFv === 1'b0) begin
            checks++;
            if (bus.instruction !== 32'h0) begin errors++; $display("[TB] FAIL rnd_bubble_instr: got %h required 0", bus.instruction); end
         end

         stallNow = ($urandom_range(0, 99) < 30);
         redirNow = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 4) == 0) begin
            target = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
         end else begin
            target = 64'($urandom_range(0, 1023)) << 2;
         end

         bus.imem_rsp_valid = 1'b0;
         if (pending) begin
            if (lat == 0) begin
               bus.imem_rsp_valid = 1'b1;
               bus.imem_rsp_data  = memWord(pendAddr);
               pending = 1'b0;
            end else begin
               lat--;
            end
         end

         readyNow = ($urandom_range(0, 99) < 70);
         bus.imem_req_ready = readyNow;
         if (readyNow && bus.imem_req_valid === 1'b1) begin
            pending  = 1'b1;
            pendAddr = bus.imem_addr;
            lat      = $urandom_range(0, 2);
         end

         if (curFv === 1'b1 && !stallNow && !redirNow) begin
            checks++;
            if (bus.PC_Out !== expPc || bus.instruction !== memWord(expPc)) begin
               errors++;
               $display("[TB] FAIL rnd_stream: got %h@%h required %h@%h",
                        bus.instruction, bus.PC_Out, memWord(expPc), expPc);
            end
            expPc = expPc + 64'd4;
            accepted++;
         end
         if (redirNow) begin
            expPc = target;
         end

         bus.stall           = stallNow;
         bus.redirect_valid  = redirNow;
         bus.redirect_target = target;
         prevHold  = stallNow && (curFv === 1'b1) && !redirNow;
         prevInstr = bus.instruction;
         prevPcOut = bus.PC_Out;
         step();
      end
      clearInputs();
      checks++;
      if (accepted < 60) begin
         errors++;
         $display("[TB] FAIL rnd_progress: accepted=%0d required 60", accepted);
      end
   endtask

   // Scenario sequence and final summary.
   initial begin
      errors = 0;
      checks = 0;
      clearInputs();
      reset = 1'b0;
      test_reset();
      test_first_fetch();
      test_back_to_back();
      test_stall_hold();
      test_redirect();
      test_reset_mid();
      test_misalign();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the 64-bit PC and issues word fetches to instruction memory over a valid/ready request and single-cycle-pulse response.
- Presents instruction, PC_Out and fetch_valid to IF/ID.
- Honours a downstream stall and a branch/jump redirect, squashing in-flight fetches.

Parameters:
- PC_WIDTH, 64, width of PC and addresses.
- INSTR_WIDTH, 32, fetched instruction width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- stall  input  1  downstream hold; outputs must not change while 1.
- redirect_valid  input  1  branch/jump taken; one-cycle pulse.
- redirect_target  input  PC_WIDTH  new PC on redirect.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  PC_WIDTH  fetch address (current PC).
- imem_rsp_valid  input  1  response data valid; single-cycle pulse; not back-pressurable.
- imem_rsp_data  input  INSTR_WIDTH  fetched instruction.
- instruction  output  INSTR_WIDTH  to IF/ID.
- PC_Out  output  PC_WIDTH  PC of instruction.
- fetch_valid  output  1  instruction/PC_Out hold a real instruction.
- fetch_misalign  output  1  optional; see Optional Feature.

Behaviour:
- Reset (async, reset==0):
  - pc=RESET_PC, state=REQ.
  - instruction=0, PC_Out=0, fetch_valid=0, imem_req_valid=0, fetch_misalign=0.
  - Hold buffer empty, squash=0.
- imem_req_valid is a registered output. It rises in the first cycle after reset deassertion and is 1 whenever state==REQ.
- imem_addr = pc.
- One request outstanding at most.
- FSM states: REQ, WAIT, HOLD.
  - REQ: req_valid=1. On req_ready, go to WAIT.
  - WAIT:
    - On rsp_valid with squash=1: discard the data, clear squash, go to REQ.
    - On rsp_valid with an output slot free (stall=0 or fetch_valid=0): instruction<=rsp_data, PC_Out<=pc, fetch_valid<=1, pc<=pc+4, go to REQ.
    - On rsp_valid with stall=1 and fetch_valid=1: capture rsp_data and pc in the hold buffer, pc<=pc+4, go to HOLD.
  - HOLD: when stall=0, move the hold buffer to the outputs (fetch_valid=1) and go to REQ.
- Output register when no new data arrives:
  - stall=1: all outputs hold.
  - stall=0: fetch_valid<=0 and instruction<=0 (bubble); PC_Out holds.
- Latency: request accept to instruction at IF/ID = response latency + 1 cycle. Back-to-back throughput is 1 instruction per 2 cycles minimum (REQ and WAIT are each at least one cycle).
- Redirect has the highest priority and overrides stall:
  - pc<=redirect_target, fetch_valid<=0, instruction<=0, hold buffer cleared.
  - In REQ without handshake: stay in REQ; the new address is presented next cycle.
  - In REQ with handshake the same cycle: go to WAIT with squash=1.
  - In WAIT with no rsp_valid this cycle: squash<=1.
  - In WAIT with rsp_valid the same cycle: drop the data, go to REQ.
  - In HOLD: go to REQ.
- PC arithmetic is modulo 2^PC_WIDTH; pc+4 wraps from all-ones-minus-3 to 0 with no flag.
- Reset asserted mid-transaction: all state clears immediately. Any late response arriving after reset deassertion while in REQ is ignored, because rsp_valid is only sampled in WAIT.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - A redirect_target with bits[1:0]!=0 is not fetched. Instead a bubble-free output is issued: fetch_valid=1, instruction=0, PC_Out=redirect_target, fetch_misalign=1 for that instruction.
  - The FSM then parks in REQ with imem_req_valid=0 until the next redirect.
  - fetch_misalign clears with the next accepted output.
- Undefined:
  - fetch_misalign is tied to 0.
  - redirect_target[1:0] is forced to 0 (word-aligned fetch).

Decomposition:
- Shared package holds:
  - PC_WIDTH and INSTR_WIDTH constants.
  - RESET_PC default.
  - NOP encoding 32'h00000013, for later bubble use.
  - The fetch-state enum {REQ, WAIT, HOLD}.
- Natural sub-module: fetch_hold_buf, a one-entry instruction/PC holding register with load/unload/clear.

Test Plan:
- Reset, then req_ready=1 and a 1-cycle response with data 0x00500093 → first output instruction=0x00500093, PC_Out=0, fetch_valid=1; next imem_addr=4.
- Three back-to-back fetches, 0-wait memory, no stall → PC_Out sequence 0, 4, 8. fetch_valid pulses with a bubble between each, because the fetch is 2-cycle.
- stall=1 while fetch_valid=1 and a response arrives → outputs unchanged, response in HOLD. After stall drops, the held instruction appears with PC_Out=4 and the next request uses addr 8.
- redirect_valid with target 0x100 while in WAIT, then response 0xDEADBEEF → response discarded, fetch_valid stays 0, next imem_addr=0x100.
- Reset pulled low during WAIT → all outputs 0 in the same cycle. After release, imem_addr=RESET_PC, and a stray rsp_valid in REQ produces no output.
- With FETCH_MISALIGN_CHK_EN: redirect to 0x102 → fetch_misalign=1, PC_Out=0x102, no imem request until the next redirect.
